// File: rtl/gap_ctrl_pkg.sv
// Shared definitions for the global-average-pooling (GAP) controller.
package gap_ctrl_pkg;

    // Width of the adder/multiplier latency wait counters (latencies 1..8).
    localparam int unsigned LAT_CNT_W = 3;

    // Operand B value used on the first pixel of a frame.
    localparam logic [31:0] ZERO_SEED = 32'h0000_0000;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SCALE = 3'd3,
        ST_DONE  = 3'd4
    } gap_state_e;

    // Pixel counter width for an n-pixel frame; never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gap_delay_line.sv
// Resettable 1-bit shift register of configurable depth.
module gap_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    if (DEPTH == 1) begin : g_one
        // Single-stage delay.
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= din;
        end
    end else begin : g_many
        // Shift din toward the MSB each cycle.
        always_ff @(posedge clk) begin
            if (rst) sr <= '0;
            else     sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/gap_ctrl.sv
// Global-average-pooling controller: sequences the accumulate / drain /
// scale / handshake phases around an external FP adder and multiplier.
// Optional feature: define GAP_CTRL_PROTO_ERR_EN to add the sticky
// Proto_Err output flagging upstream valid while a frame is being finished.
module gap_ctrl
    import gap_ctrl_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 44,
    parameter int unsigned IMG_HEIGHT = 44,
    parameter int unsigned ADD_LAT    = 1,
    parameter int unsigned MUL_LAT    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic Valid_In,
    output logic Ready_Out,
    output logic Acc_Seed,
    output logic Acc_En,
    output logic Mul_Start,
    output logic Valid_Out,
    input  logic Ready_In,
    output logic [count_width(IMG_WIDTH*IMG_HEIGHT)-1:0] Pix_Count,
`ifdef GAP_CTRL_PROTO_ERR_EN
    output logic Proto_Err,
`endif
    output logic Busy
);

    localparam int unsigned N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CW = count_width(N);

    localparam bit                   SINGLE_PIX = (N == 1);
    localparam bit                   ADD_SINGLE = (ADD_LAT == 1);
    localparam logic [LAT_CNT_W-1:0] ADD_WAIT   = LAT_CNT_W'(ADD_LAT - 1);
    localparam logic [LAT_CNT_W-1:0] MUL_WAIT   = LAT_CNT_W'(MUL_LAT - 1);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE    = LAT_CNT_W'(1);
    localparam logic [CW-1:0]        LAST_IDX   = CW'(N - 1);
    localparam logic [CW-1:0]        CNT_ONE    = CW'(1);

    gap_state_e           state;
    logic [LAT_CNT_W-1:0] space_cnt;
    logic [LAT_CNT_W-1:0] wait_cnt;
    logic                 xfer;

    // Upstream transfer strobe and zero-seed select for the first pixel.
    assign xfer     = Valid_In & Ready_Out;
    assign Acc_Seed = xfer & (state == ST_IDLE);

    // Accumulator load enable lines up with the adder result.
    gap_delay_line #(
        .DEPTH (ADD_LAT)
    ) u_acc_en_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (xfer),
        .dout (Acc_En)
    );

    // Frame sequencer with registered handshake/control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            Pix_Count <= '0;
            space_cnt <= '0;
            wait_cnt  <= '0;
            Mul_Start <= 1'b0;
            Valid_Out <= 1'b0;
            Busy      <= 1'b0;
            Ready_Out <= 1'b1;
        end else begin
            Mul_Start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        Pix_Count <= CNT_ONE;
                        Busy      <= 1'b1;
                        if (SINGLE_PIX) begin
                            state     <= ST_DRAIN;
                            wait_cnt  <= ADD_WAIT;
                            Ready_Out <= 1'b0;
                        end else begin
                            state     <= ST_ACCUM;
                            space_cnt <= ADD_WAIT;
                            Ready_Out <= ADD_SINGLE;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (space_cnt != '0) begin
                        // Hold off until the previous add has landed.
                        space_cnt <= space_cnt - LAT_ONE;
                        if (space_cnt == LAT_ONE) Ready_Out <= 1'b1;
                    end else if (xfer) begin
                        if (Pix_Count == LAST_IDX) begin
                            state     <= ST_DRAIN;
                            wait_cnt  <= ADD_WAIT;
                            Ready_Out <= 1'b0;
                        end else begin
                            Pix_Count <= Pix_Count + CNT_ONE;
                            space_cnt <= ADD_WAIT;
                            Ready_Out <= ADD_SINGLE;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_SCALE;
                        Mul_Start <= 1'b1;
                        wait_cnt  <= MUL_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_ONE;
                    end
                end

                ST_SCALE: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_DONE;
                        Valid_Out <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_ONE;
                    end
                end

                ST_DONE: begin
                    if (Ready_In) begin
                        state     <= ST_IDLE;
                        Valid_Out <= 1'b0;
                        Pix_Count <= '0;
                        Busy      <= 1'b0;
                        Ready_Out <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    Pix_Count <= '0;
                    space_cnt <= '0;
                    wait_cnt  <= '0;
                    Valid_Out <= 1'b0;
                    Busy      <= 1'b0;
                    Ready_Out <= 1'b1;
                end
            endcase
        end
    end

`ifdef GAP_CTRL_PROTO_ERR_EN
    // Sticky flag: upstream offered data while a frame was being finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            Proto_Err <= 1'b0;
        end else if (Valid_In && (state == ST_DRAIN || state == ST_SCALE ||
                                  state == ST_DONE)) begin
            Proto_Err <= 1'b1;
        end
    end
`endif

endmodule
